// File: rtl/line_buffer_unit.sv
// Line buffer feeding the pixel unit: keeps the NM-1 most recent lines in rotating
// single-port line memories and emits one NM-tall pixel column per accepted pixel.
module line_buffer_unit #(
  parameter int XB    = 10,
  parameter int YB    = 10,
  parameter int PB    = 8,
  parameter int NM    = 4,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [PB-1:0] pix_in,
  input  logic          pix_in_valid,
  output logic          pix_in_ready,
  output logic [PB-1:0] col_data [NM-1:0],
  output logic          en,
  output logic          eol,
  output logic          frame_done
);

  localparam int LB = (NM > 1) ? $clog2(NM) : 1;
  localparam int AB = $clog2(IMG_W);

  localparam logic [XB-1:0] X_LAST      = XB'(IMG_W - 1);
  localparam logic [YB-1:0] Y_LAST      = YB'(IMG_H - 1);
  localparam logic [YB-1:0] Y_FILL_LAST = YB'(NM - 2);
  localparam logic [LB-1:0] L_LAST      = LB'(NM - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FILL,
    S_STREAM
  } state_t;

  state_t state_reg, state_next;

  logic [XB-1:0] x_reg;
  logic [YB-1:0] y_reg;
  logic [LB-1:0] wr_line_reg;
  logic [LB-1:0] base_reg;
  logic [AB-1:0] addr;

  logic accept;
  logic streaming;
  logic x_wrap;
  logic fill_last;
  logic frame_last;

  logic          en_reg;
  logic          eol_reg;
  logic          frame_done_reg;
  logic [PB-1:0] pix_reg;
  logic [PB-1:0] rd_word [NM];

  assign accept     = pix_in_valid & pix_in_ready;
  assign x_wrap     = (x_reg == X_LAST);
  assign fill_last  = x_wrap && (y_reg == Y_FILL_LAST);
  assign frame_last = x_wrap && (y_reg == Y_LAST);
  assign addr       = x_reg[AB-1:0];

  // Frame FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= S_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Frame FSM: next state
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      S_IDLE:   if (start)                  state_next = S_FILL;
      S_FILL:   if (accept && fill_last)    state_next = S_STREAM;
      S_STREAM: if (accept && frame_last)   state_next = S_IDLE;
      default:                              state_next = S_IDLE;
    endcase
  end

  // Frame FSM: outputs
  always_comb begin
    pix_in_ready = 1'b0;
    streaming    = 1'b0;
    case (state_reg)
      S_FILL: begin
        pix_in_ready = 1'b1;
      end
      S_STREAM: begin
        pix_in_ready = 1'b1;
        streaming    = 1'b1;
      end
      default: begin
        pix_in_ready = 1'b0;
        streaming    = 1'b0;
      end
    endcase
  end

  // Raster position and the line memory currently being written
  always_ff @(posedge clk) begin
    if (rst) begin
      x_reg       <= '0;
      y_reg       <= '0;
      wr_line_reg <= '0;
    end else if (state_reg == S_IDLE && start) begin
      x_reg       <= '0;
      y_reg       <= '0;
      wr_line_reg <= '0;
    end else if (accept) begin
      if (x_wrap) begin
        x_reg       <= '0;
        y_reg       <= y_reg + 1'b1;
        wr_line_reg <= (wr_line_reg == L_LAST) ? '0 : wr_line_reg + 1'b1;
      end else begin
        x_reg <= x_reg + 1'b1;
      end
    end
  end

  // Column qualifiers and the live pixel line up with the 1-cycle RAM read
  always_ff @(posedge clk) begin
    if (rst) begin
      en_reg         <= 1'b0;
      eol_reg        <= 1'b0;
      frame_done_reg <= 1'b0;
      pix_reg        <= '0;
      base_reg       <= '0;
    end else begin
      en_reg         <= accept & streaming;
      eol_reg        <= accept & streaming & x_wrap;
      frame_done_reg <= accept & streaming & frame_last;
      if (accept) begin
        pix_reg  <= pix_in;
        base_reg <= wr_line_reg;
      end
    end
  end

  assign en         = en_reg;
  assign eol        = eol_reg;
  assign frame_done = frame_done_reg;

  // One line memory per row slot; the slot being written is never read that cycle
  genvar gi;
  generate
    for (gi = 0; gi < NM; gi++) begin : g_line
      logic [PB-1:0] mem [IMG_W];
      logic [PB-1:0] rd_reg;
      logic          wr_en;
      logic          rd_en;

      assign wr_en = accept && (wr_line_reg == LB'(gi));
      assign rd_en = accept && !wr_en;

      always_ff @(posedge clk) begin
        if (wr_en) begin
          mem[addr] <= pix_in;
        end
      end

      always_ff @(posedge clk) begin
        if (rst) begin
          rd_reg <= '0;
        end else if (rd_en) begin
          rd_reg <= mem[addr];
        end
      end

      assign rd_word[gi] = rd_reg;
    end

    // Oldest stored line sits in the slot just after the one being written
    for (gi = 0; gi < NM - 1; gi++) begin : g_col
      logic [LB:0]   sum;
      logic [LB-1:0] sel;

      assign sum = {1'b0, base_reg} + (LB+1)'(gi + 1);
      assign sel = (sum >= (LB+1)'(NM)) ? LB'(sum - (LB+1)'(NM)) : sum[LB-1:0];
      assign col_data[gi] = rd_word[sel];
    end
  endgenerate

  assign col_data[NM-1] = pix_reg;

endmodule

// File: tb/tb_line_buffer_unit.sv
// Directed bench for line_buffer_unit: 8x6 frames, NM=4, pixel = y*16 + x (+ frame offset).
module tb_line_buffer_unit;

  localparam int W = 8;
  localparam int H = 6;
  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] pix_in;
  logic       pix_in_valid;
  logic       pix_in_ready;
  logic [7:0] col_data [N-1:0];
  logic       en;
  logic       eol;
  logic       frame_done;

  int n_vec  = 0;
  int n_miss = 0;
  int n_cols = 0;

  always #5 clk = ~clk;

  line_buffer_unit #(
    .XB(10), .YB(10), .PB(8), .NM(N), .IMG_W(W), .IMG_H(H)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .pix_in       (pix_in),
    .pix_in_valid (pix_in_valid),
    .pix_in_ready (pix_in_ready),
    .col_data     (col_data),
    .en           (en),
    .eol          (eol),
    .frame_done   (frame_done)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Outputs are examined 1 time unit after the edge that consumed the inputs
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Feed one frame; stops before pixel (4, stop_y) when stop_y < H
  task automatic feed(input int off, input int stop_y, input bit gaps);
    n_cols = 0;
    for (int y = 0; y < H; y++) begin
      for (int x = 0; x < W; x++) begin
        if (y == stop_y && x == 4) begin
          pix_in_valid = 1'b0;
          return;
        end
        if (gaps && y == 4 && x == 3) begin
          pix_in_valid = 1'b0;
          repeat (2) begin
            step();
            check("gap_en", en, 0);
          end
        end
        pix_in       = 8'(y * 16 + x + off);
        pix_in_valid = 1'b1;
        start        = (y == 2 && x == 2);
        step();
        start = 1'b0;
        if (en) n_cols++;
        if (y < N - 1) begin
          check("fill_en", en, 0);
        end else begin
          check("en", en, 1);
          for (int i = 0; i < N - 1; i++)
            check($sformatf("col%0d", i), col_data[i], (y - (N - 1) + i) * 16 + x + off);
          check("col_live", col_data[N-1], y * 16 + x + off);
          check("eol", eol, (x == W - 1));
          check("done", frame_done, (x == W - 1 && y == H - 1));
          $display("col (%0d,%0d) %02h %02h %02h %02h eol=%0b done=%0b",
                   x, y, col_data[0], col_data[1], col_data[2], col_data[3], eol, frame_done);
        end
        check("ready", pix_in_ready, !(x == W - 1 && y == H - 1));
      end
    end
    pix_in_valid = 1'b0;
  endtask

  initial begin
    rst          = 1'b1;
    start        = 1'b0;
    pix_in       = 8'h00;
    pix_in_valid = 1'b0;
    step();
    step();
    check("rst_en", en, 0);
    check("rst_eol", eol, 0);
    check("rst_done", frame_done, 0);
    check("rst_ready", pix_in_ready, 0);
    for (int i = 0; i < N; i++) check($sformatf("rst_col%0d", i), col_data[i], 0);

    rst = 1'b0;
    step();
    check("idle_ready", pix_in_ready, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("start_ready", pix_in_ready, 1);

    // Frame 1: full frame with a 2-cycle gap in row 4 and a stray start in row 2
    feed(0, H, 1'b1);
    check("col_count1", n_cols, 24);
    pix_in       = 8'hAA;
    pix_in_valid = 1'b1;
    step();
    check("post_en", en, 0);
    check("post_done", frame_done, 0);
    check("post_ready", pix_in_ready, 0);
    pix_in_valid = 1'b0;

    // Frame 2: aborted by reset during row 4 with a pixel on the input
    start = 1'b1;
    step();
    start = 1'b0;
    feed(8'h80, 4, 1'b0);
    pix_in       = 8'hEE;
    pix_in_valid = 1'b1;
    rst          = 1'b1;
    step();
    check("abort_en", en, 0);
    check("abort_done", frame_done, 0);
    check("abort_ready", pix_in_ready, 0);
    rst          = 1'b0;
    pix_in_valid = 1'b0;
    step();
    check("abort_idle", pix_in_ready, 0);

    // Frame 3: must refill from scratch after the reset
    start = 1'b1;
    step();
    start = 1'b0;
    feed(8'h08, H, 1'b0);
    check("col_count3", n_cols, 24);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
